// File: rtl/axil_ram_bist_if.sv
// AXI4-Lite bus bundle used between the RAM self-test master and the RAM slave.
// Master drives addresses, data and ready for responses; slave drives the rest.
interface axil_ram_bist_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_ram_bist.sv
// AXI4-Lite master running a four-pass write/verify march (pattern, then inverted
// pattern) over a RAM window; reports pass/fail, saturating error count, first bad address.
module axil_ram_bist #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(32'hA5A5_0000),
  parameter int                    ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  axil_ram_bist_if.master       m_axil
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    FIN
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [1:0]            pass_idx_q, pass_idx_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;

  logic [ADDR_WIDTH-1:0] addr_cur;
  logic [DATA_WIDTH-1:0] pat_cur;
  logic [DATA_WIDTH-1:0] data_cur;
  logic                  err_hit;
  logic                  step;

  // Passes 2 and 3 use the inverted pattern, so bit 1 of the pass counter selects polarity.
  assign addr_cur = BASE_ADDR + (ADDR_WIDTH'(index_q) * ADDR_WIDTH'(STRB_WIDTH));
  assign pat_cur  = DATA_WIDTH'(index_q) ^ SEED;
  assign data_cur = pass_idx_q[1] ? ~pat_cur : pat_cur;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    pass_idx_d  = pass_idx_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    fail_addr_d = fail_addr_q;
    err_hit     = 1'b0;
    step        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = '0;
          fail_addr_d = '0;
          busy_d      = 1'b1;
          index_d     = '0;
          pass_idx_d  = '0;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          state_d     = WADDR;
        end
      end
      WADDR: begin
        if (m_axil.awready) awvalid_d = 1'b0;
        if (m_axil.wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WRESP;
      end
      WRESP: begin
        if (m_axil.bvalid) begin
          err_hit = (m_axil.bresp != 2'b00);
          step    = 1'b1;
        end
      end
      RADDR: begin
        if (m_axil.arready) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (m_axil.rvalid) begin
          err_hit = (m_axil.rdata != data_cur) || (m_axil.rresp != 2'b00);
          step    = 1'b1;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_count_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The counter never returns to zero within a run, so zero marks the first error.
    if (err_hit) begin
      if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
      if (err_count_q == '0) fail_addr_d = addr_cur;
    end

    if (step) begin
      if (index_q == LAST_IDX) begin
        index_d    = '0;
        pass_idx_d = pass_idx_q + 2'd1;
      end else begin
        index_d = index_q + 1'b1;
      end
      if (index_q == LAST_IDX && pass_idx_q == 2'd3) begin
        state_d = FIN;
      end else if (pass_idx_d[0]) begin
        arvalid_d = 1'b1;
        state_d   = RADDR;
      end else begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        state_d   = WADDR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      index_q     <= '0;
      pass_idx_q  <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      pass_idx_q  <= pass_idx_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_addr = fail_addr_q;

  assign m_axil.awaddr  = addr_cur;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = data_cur;
  assign m_axil.wstrb   = '1;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = (state_q == WRESP);
  assign m_axil.araddr  = addr_cur;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = (state_q == RDATA);

endmodule

// File: doc/axil_ram_bist.md
Name: axil_ram_bist

Overview:
AXI4-Lite master that runs a self-test over a word-aligned address window of an AXI-Lite RAM slave. Runs a four-pass write/verify march: true pattern, then inverted pattern. Used at bring-up and in the memory benchmark harness. Reports pass/fail, a saturating error count and the first failing address.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8
ADDR_WIDTH, 16, byte address width
STRB_WIDTH, DATA_WIDTH/8, write-strobe width
BASE_ADDR, 0, byte address of the first word under test; STRB_WIDTH-aligned
DEPTH, 256, number of words tested; must be >= 1 and fit in the address space
SEED, 32'hA5A5_0000, DATA_WIDTH-wide XOR seed for the pattern
ERR_WIDTH, 16, width of the error counter

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when idle
busy  out  1  high from the cycle after an accepted start until the run ends
done  out  1  high after a run completes; cleared by the next accepted start
pass  out  1  valid while done; 1 iff err_count==0
err_count  out  ERR_WIDTH  mismatches plus error responses, saturating
fail_addr  out  ADDR_WIDTH  byte address of the first error in the run; 0 if none
m_axil_awaddr  out  ADDR_WIDTH  write address
m_axil_awvalid  out  1  write address valid
m_axil_awready  in  1  write address ready
m_axil_wdata  out  DATA_WIDTH  write data
m_axil_wstrb  out  STRB_WIDTH  write strobe; always all ones
m_axil_wvalid  out  1  write data valid
m_axil_wready  in  1  write data ready
m_axil_bresp  in  2  write response
m_axil_bvalid  in  1  write response valid
m_axil_bready  out  1  write response ready
m_axil_araddr  out  ADDR_WIDTH  read address
m_axil_arvalid  out  1  read address valid
m_axil_arready  in  1  read address ready
m_axil_rdata  in  DATA_WIDTH  read data
m_axil_rresp  in  2  read response
m_axil_rvalid  in  1  read data valid
m_axil_rready  out  1  read data ready

Behaviour:
- Reset (async, rst_n=0): state IDLE. All valid/ready outputs 0, busy=0, done=0, pass=0, err_count=0, fail_addr=0, index=0, pass counter=0. Reset mid-run abandons the outstanding transaction without completing the handshake; the slave must be reset alongside this block.
- Pattern: pat(i) = zero-extend(i, DATA_WIDTH) XOR SEED. addr(i) = BASE_ADDR + i*STRB_WIDTH, truncated to ADDR_WIDTH.
- Passes run in order: P0 write pat, P1 read and compare against pat, P2 write ~pat, P3 read and compare against ~pat. Index i runs 0..DEPTH-1 in each pass.
- States: IDLE -> WADDR -> WRESP -> (next index or next pass) ... RADDR -> RDATA -> ... -> FIN -> IDLE.
- IDLE: start=1 clears done, err_count and fail_addr, sets busy=1 and enters WADDR for P0. start is ignored in every other state.
- WADDR: assert awvalid and wvalid together with addr(i) and data. Each valid drops independently on its own handshake. Move to WRESP once both have handshaked, including the case where both handshake in the same cycle.
- WRESP: bready=1. On bvalid, bresp!=0 counts one error. Then advance to the next index, or to the next pass after i==DEPTH-1.
- RADDR: arvalid=1 until arready. RDATA: rready=1. On rvalid, rdata!=expected or rresp!=0 counts one error; a word that both mismatches and has a bad response counts once.
- At most one transaction outstanding at any time. No combinational path from inputs to outputs.
- Error count: err_count += 1, saturating at 2^ERR_WIDTH-1. fail_addr latches addr(i) on the first error of the run only.
- FIN: one cycle. busy=0, done=1, pass=(err_count==0). Return to IDLE. done holds until the next start.
- DEPTH=1: each pass has exactly one transaction. Address wrap past 2^ADDR_WIDTH is a configuration error and is not checked.

Test Plan:
- Connect to a fault-free AXI-Lite RAM with DATA_WIDTH=32, DEPTH=16, BASE_ADDR=0x40, pulse start -> exactly 32 writes and 32 reads; awaddr for i=3 is 0x4C with wdata 0xA5A5_0003 in P0 and 0x5A5A_FFFC in P2; done=1, pass=1, err_count=0, fail_addr=0.
- Monitor flips rdata bit 0 for i=5 in P1 only -> err_count=1, fail_addr=0x54, pass=0.
- Slave returns bresp=2'b10 for i=2 in P0 and rresp=2'b10 for i=9 in P3 -> err_count=2, fail_addr=0x48.
- Random stalls on awready, wready, bvalid, arready and rvalid, with aw and w accepted in different cycles -> no more than one transaction outstanding; valids stable until handshake; result identical to the first test.
- start pulsed while busy -> ignored and the run completes normally. ERR_WIDTH=2 with every read corrupted -> err_count saturates at 3.
- Deassert rst_n during P1 -> all outputs return to reset values immediately; after reset, a new start runs to pass=1.
